// File: rtl/lights_pkg.sv
// Shared encodings for the LED demo blocks: pattern modes, scanner FSM states, travel direction.
package lights_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BAR    = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_RESTART = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..T-1 with T = CLK_DIV >> speed, emitting tick on the terminal count.
module tick_prescaler #(
    parameter int CLK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] count;
    logic [CW-1:0] term;

    assign term = CW'((CLK_DIV >> speed) - 1);
    // >= rather than == so a speed increase past the current count fires at once.
    assign tick = enable && (count >= term);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (enable)
            count <= (count >= term) ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/lights_scanner.sv
// Parametrised LED pattern generator (bounce / rotate / bar / hold) with step and cycle_done pulses.
// Optional LIGHTS_SCANNER_TAIL_EN: also light the LED just behind the head in bounce and rotate.
import lights_pkg::*;

module lights_scanner #(
    parameter int N_LEDS  = 8,
    parameter int CLK_DIV = 12500000,
    parameter int PW      = $clog2(N_LEDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] leds,
    output logic              step,
    output logic              cycle_done
);

    localparam logic [PW-1:0]     TOP  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]     FULL = PW'(N_LEDS);
    localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] ALL  = '1;

    state_t            state, state_nx;
    logic [1:0]        mode_q;
    logic [PW-1:0]     pos, pos_nx, level, level_nx;
    logic              dir, dir_nx;
    logic [N_LEDS-1:0] leds_nx, tail;
    logic              cd_nx, tick, restart, presc_rst;

    assign restart   = (state == ST_RESTART) || (mode != mode_q);
    // A restart clears the prescaler so the first step after it is a full period away.
    assign presc_rst = reset && !restart;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .clk    (clk),
        .reset  (presc_rst),
        .enable (enable),
        .speed  (speed),
        .tick   (tick)
    );

`ifdef LIGHTS_SCANNER_TAIL_EN
    // The position being left is always the one behind the head, including at a reversal.
    assign tail = ONE << pos;
`else
    assign tail = '0;
`endif

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        dir_nx   = dir;
        level_nx = level;
        leds_nx  = leds;
        cd_nx    = 1'b0;
        if (restart) begin
            state_nx = (mode == MODE_HOLD) ? ST_HOLD : ST_RUN;
            pos_nx   = TOP;
            dir_nx   = DIR_DOWN;
            level_nx = '0;
            if (mode == MODE_BAR)
                leds_nx = '0;
            else if (mode != MODE_HOLD)
                leds_nx = ONE << TOP;
        end else if (state == ST_RUN && tick) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir == DIR_DOWN) begin
                        if (pos == '0) begin
                            pos_nx = PW'(1);
                            dir_nx = DIR_UP;
                        end else
                            pos_nx = pos - 1'b1;
                    end else if (pos == TOP) begin
                        pos_nx = TOP - 1'b1;
                        dir_nx = DIR_DOWN;
                    end else
                        pos_nx = pos + 1'b1;
                    cd_nx = (pos_nx == TOP);
                end
                MODE_ROTATE: begin
                    pos_nx = (pos == '0) ? TOP : pos - 1'b1;
                    cd_nx  = (pos == '0);
                end
                default: begin
                    // Bar starts at level 0 pointing down, so the first step flips it to filling.
                    if (dir == DIR_DOWN) begin
                        if (level == '0) begin
                            level_nx = PW'(1);
                            dir_nx   = DIR_UP;
                        end else
                            level_nx = level - 1'b1;
                    end else if (level == FULL) begin
                        level_nx = FULL - 1'b1;
                        dir_nx   = DIR_DOWN;
                    end else
                        level_nx = level + 1'b1;
                    cd_nx = (level_nx == '0);
                end
            endcase
            if (mode_q == MODE_BAR)
                leds_nx = ~(ALL >> level_nx);
            else
                leds_nx = (ONE << pos_nx) | tail;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_RESTART;
            mode_q     <= mode;
            pos        <= TOP;
            dir        <= DIR_DOWN;
            level      <= '0;
            leds       <= '0;
            step       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nx;
            mode_q     <= mode;
            pos        <= pos_nx;
            dir        <= dir_nx;
            level      <= level_nx;
            leds       <= leds_nx;
            step       <= tick && !restart;
            cycle_done <= cd_nx;
        end
    end

endmodule

// File: tb/tb_lights_scanner.sv
// Directed + randomized bench for lights_scanner against a frame-table reference model.
module tb_lights_scanner;

    localparam int N  = 8;
    localparam int CD = 8;

    logic         clk = 1'b0;
    logic         reset, enable;
    logic [1:0]   mode, speed;
    logic [N-1:0] leds;
    logic         step, cycle_done;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_leds;
    logic         m_step, m_cd, m_restart;
    int           m_cnt, m_idx, m_mode_q;

    always #5 clk = ~clk;

    lights_scanner #(.N_LEDS(N), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .speed      (speed),
        .leds       (leds),
        .step       (step),
        .cycle_done (cycle_done)
    );

    function automatic int period(input int md);
        case (md)
            0:       return 2 * N - 2;
            1:       return N;
            default: return 2 * N;
        endcase
    endfunction

    // Frame k of a pattern, computed directly from the pattern's definition.
    function automatic logic [N-1:0] frame(input int md, input int k);
        int p, lv;
        case (md)
            0: begin
                p = (k < N) ? N - 1 - k : k - (N - 1);
                return N'(1 << p);
            end
            1: return N'(1 << (N - 1 - k));
            default: begin
                lv = (k <= N) ? k : 2 * N - k;
                return N'(((1 << lv) - 1) << (N - lv));
            end
        endcase
    endfunction

    task automatic model_edge();
        int  md, t;
        bit  tk;
        md = int'(mode);
        if (!reset) begin
            m_leds = '0; m_step = 1'b0; m_cd = 1'b0; m_cnt = 0; m_idx = 0;
            m_restart = 1'b1; m_mode_q = md;
        end else if (m_restart || md != m_mode_q) begin
            m_mode_q = md; m_cnt = 0; m_idx = 0; m_step = 1'b0; m_cd = 1'b0; m_restart = 1'b0;
            if (md != 3) m_leds = frame(md, 0);
        end else begin
            t  = CD >> speed;
            tk = enable && (m_cnt >= t - 1);
            if (enable) m_cnt = tk ? 0 : m_cnt + 1;
            m_step = tk;
            m_cd   = 1'b0;
            if (tk && md != 3) begin
                m_idx  = (m_idx + 1) % period(md);
                m_leds = frame(md, m_idx);
                m_cd   = (m_idx == 0);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("leds", 32'(leds), 32'(m_leds));
        chk("step", 32'(step), 32'(m_step));
        chk("cycle_done", 32'(cycle_done), 32'(m_cd));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; mode = 2'd0; speed = 2'd3;
        m_leds = '0; m_step = 1'b0; m_cd = 1'b0; m_restart = 1'b1;
        m_cnt = 0; m_idx = 0; m_mode_q = 0;

        // reset: dark
        repeat (3) cyc();
        chk("reset_dark", 32'(leds), 32'h0);

        // bounce at full speed
        reset = 1'b1;
        cyc();
        chk("first_frame", 32'(leds), 32'h80);
        repeat (20) cyc();

        // rotate, slowest speed
        mode = 2'd1; speed = 2'd0;
        repeat (80) cyc();

        // bar fill/empty
        mode = 2'd2; speed = 2'd3;
        cyc();
        chk("bar_start", 32'(leds), 32'h0);
        repeat (40) cyc();

        // pause mid-period
        mode = 2'd1; speed = 2'd0;
        repeat (13) cyc();
        enable = 1'b0;
        repeat (20) cyc();
        enable = 1'b1;
        repeat (12) cyc();

        // mode switch bounce -> rotate while leds = 04
        mode = 2'd0; speed = 2'd3;
        for (int i = 0; i < 40 && m_leds != N'(8'h04); i++) cyc();
        chk("reach_04", 32'(leds), 32'h04);
        mode = 2'd1;
        cyc();
        chk("switch_leds", 32'(leds), 32'h80);
        chk("switch_step", 32'(step), 32'h0);
        cyc();
        chk("after_switch", 32'(leds), 32'h40);

        // speed 0 -> 3 with count 5 fires immediately
        speed = 2'd0;
        for (int i = 0; i < 40 && m_cnt != 5; i++) cyc();
        chk("reach_cnt5", 32'(m_cnt), 32'd5);
        speed = 2'd3;
        cyc();
        chk("fast_tick", 32'(step), 32'h1);

        // reset mid-pattern at leds = 10
        for (int i = 0; i < 40 && m_leds != N'(8'h10); i++) cyc();
        chk("reach_10", 32'(leds), 32'h10);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("reset_hold", 32'(leds), 32'h0);
        end
        reset = 1'b1;
        cyc();
        chk("release_leds", 32'(leds), 32'h80);

        // randomized traffic including hold mode and sparse resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) enable = ~enable;
            reset = ($urandom_range(99) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
